// File: rtl/shift_sub_divider_if.sv
// Handshake and operand/result bundle for the shift-subtract divider.
// The master drives start and the operands; the slave returns the results and status.
interface shift_sub_divider_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_zero
  );
endinterface

// File: rtl/shift_sub_divider.sv
// Sequential restoring unsigned divider: one quotient bit per clock, N+1 cycles per result.
// A zero divisor short-circuits straight to DONE with an all-ones quotient.
module shift_sub_divider #(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               reset,
  shift_sub_divider_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N:0]     rem_q, rem_d;
  logic [N-1:0]   dvsr_q, dvsr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic           div_zero_q, div_zero_d;

  logic [N:0]     shifted_rem;
  logic [N:0]     trial;
  logic           trial_neg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      quo_q       <= '0;
      rem_q       <= '0;
      dvsr_q      <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvsr_q      <= dvsr_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvsr_d      = dvsr_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    // The partial remainder always stays below the divisor, so its top bit
    // is zero before the shift and the N+1-bit window loses nothing.
    shifted_rem = (N + 1)'({rem_q, quo_q[N-1]});
    trial_neg   = shifted_rem < {1'b0, dvsr_q};
    trial       = shifted_rem - {1'b0, dvsr_q};

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          if (bus.divisor != '0) begin
            quo_d      = bus.dividend;
            rem_d      = '0;
            dvsr_d     = bus.divisor;
            count_d    = CW'(N);
            div_zero_d = 1'b0;
            state_d    = S_ITER;
          end else begin
            quotient_d  = '1;
            remainder_d = bus.dividend;
            div_zero_d  = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_ITER: begin
        quo_d   = {quo_q[N-2:0], ~trial_neg};
        rem_d   = trial_neg ? shifted_rem : trial;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          quotient_d  = quo_d;
          remainder_d = rem_d[N-1:0];
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy      = (state_q == S_ITER);
  assign bus.done      = (state_q == S_DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;
endmodule

// File: doc/shift_sub_divider.md
Name: shift_sub_divider

Overview:
- Sequential restoring (shift-subtract) unsigned integer divider; the inverse of the team's shift-add multiplier datapath.
- Integrates the datapath registers with its own controller FSM and computes one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit. A start/busy/done handshake drives it, and it returns quotient, remainder and a divide-by-zero flag.

Parameters:
- N, 4, operand width in bits (dividend, divisor, quotient, remainder); legal N >= 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  request; sampled only when busy=0
- dividend  input  N  unsigned dividend, sampled on accepted start
- divisor  input  N  unsigned divisor, sampled on accepted start
- quotient  output  N  result quotient
- remainder  output  N  result remainder
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: results valid
- div_zero  output  1  last operation had divisor==0

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - quotient, remainder, busy, done and div_zero all go to 0.
  - Internal count, divisor register and (N+1)-bit partial remainder are cleared.
  - Reset mid-operation abandons the operation with no done pulse.
- States: IDLE, ITER, DONE.
- IDLE (busy=0): at a clock edge with start=1:
  - If divisor!=0: load quo_reg<=dividend, rem_reg<=0, dvsr<=divisor, count<=N, div_zero<=0; go to ITER.
  - If divisor==0: quotient<={N{1'b1}}, remainder<=dividend, div_zero<=1; go to DONE with no iterations.
- ITER (busy=1): each edge performs one step:
  - Shift {rem_reg,quo_reg} left 1; trial = shifted rem_reg - {1'b0,dvsr}, computed in N+1 bits.
  - trial non-negative: rem_reg<=trial, quo_reg[0]<=1.
  - trial negative: restore (keep shifted rem_reg), quo_reg[0]<=0.
  - Decrement count. On the step where count reaches 0, copy results to quotient/remainder and go to DONE.
- DONE: done=1 for exactly one cycle, busy=0. quotient, remainder and div_zero remain valid and held until the next accepted start. Next edge returns to IDLE.
- start during DONE is accepted exactly as in IDLE, allowing back-to-back operation.
- start while busy=1 is ignored; operands are not resampled.
- Latency: start accepted at edge E0 (divisor!=0) → busy high after E0 → N iteration edges E1..EN → done=1 in the cycle after EN. Throughput is one result per N+1 cycles.
- Divide-by-zero latency: done=1 in the cycle after E0.
- quotient/remainder are output registers: unchanged during ITER, updated only on entry to DONE.
- Result invariant (divisor!=0): dividend == quotient*divisor + remainder, with remainder < divisor.
- Arithmetic is unsigned only. Internal partial remainder is N+1 bits so the trial subtraction never overflows. Outputs are the low N bits.
- done and busy are never high together.

Test Plan:
- N=4, dividend=13, divisor=4, start pulse → busy 4 cycles, then done=1 for 1 cycle with quotient=3, remainder=1, div_zero=0; outputs held afterward.
- dividend=15, divisor=1 → quotient=15, remainder=0; dividend=15, divisor=15 → quotient=1, remainder=0; dividend=3, divisor=9 → quotient=0, remainder=3.
- dividend=7, divisor=0 → done one cycle after start, quotient=4'hF, remainder=7, div_zero=1. A following 8/2 gives quotient=4, remainder=0, div_zero=0.
- start 13/4, then start=1 with 9/2 on the 2nd busy cycle → ignored; result is still 3 r1 and no extra done pulse.
- start=1 with 9/2 held on the DONE cycle of a prior op → accepted; next done gives quotient=4, remainder=1 after N cycles.
- Assert reset=0 asynchronously mid-ITER (between clock edges) → busy, done, quotient and remainder go to 0 immediately. After release, 14/3 gives quotient=4, remainder=2.
- Exhaustive sweep for N=4 (all 256 operand pairs) against the reference model, checking the invariant and latency.
